reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer.sv | 162 ++++++++++++++++
 tb/tb_reaction_timer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer.sv
// Purpose: measures driver reaction time in ms from lights_out to button press, tracks best time.
// Latency: press acted on 3 clks after resp rises; valid and rt_ms update together, best_ms 1 clk later.
// Backpressure: none; all inputs are single-cycle pulses or levels, outputs have no ready handshake.

// Button conditioning: 2-flop synchronizer, rising-edge detect, and a
// release gate so a button already held when reset lifts is ignored until
// it has been seen released at least once.
module reaction_timer_sync (
    input  logic clk,
    input  logic rst,
    input  logic resp,
    output logic press
);

    logic       sync1;
    logic       sync2;
    logic       sync_d;
    logic       rel_seen;
    logic [1:0] settle;

    // sync2 only reflects the real button level once two clocks have
    // passed since reset; settle counts those clocks so the release gate
    // never trusts the reset-zeroed pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sync_d   <= 1'b0;
            rel_seen <= 1'b0;
            settle   <= 2'd0;
        end else begin
            sync1  <= resp;
            sync2  <= sync1;
            sync_d <= sync2;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            if ((settle == 2'd2) && !sync2) begin
                rel_seen <= 1'b1;
            end
        end
    end

    // One-clock press on the rising edge of the synchronized level.
    assign press = sync2 & ~sync_d & rel_seen;

endmodule

module reaction_timer #(
    parameter int MAX_MS = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_ms,
    input  logic        arm,
    input  logic        lights_out,
    input  logic        resp,
    input  logic        clear_best,
    output logic [13:0] rt_ms,
    output logic [13:0] best_ms,
    output logic        valid,
    output logic        jump_start,
    output logic        timeout,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARMED  = 3'd1;
    localparam logic [2:0] S_TIMING = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_JUMP   = 3'd4;
    localparam logic [2:0] S_TOUT   = 3'd5;

    localparam logic [13:0] MAX_V  = 14'(MAX_MS);
    localparam logic [13:0] LAST_V = MAX_V - 14'd1;

    logic [2:0]  state;
    logic [13:0] count;
    logic        press;

    reaction_timer_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .resp  (resp),
        .press (press)
    );

    // Measurement FSM and counter; press always takes priority over
    // lights_out in ARMED and over the saturating tick in TIMING.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            count      <= 14'd0;
            rt_ms      <= 14'd0;
            valid      <= 1'b0;
            jump_start <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (press) begin
                        state      <= S_JUMP;
                        jump_start <= 1'b1;
                        rt_ms      <= 14'd0;
                    end else if (lights_out) begin
                        state <= S_TIMING;
                        count <= 14'd0;
                    end
                end
                S_TIMING: begin
                    if (press) begin
                        // Capture the pre-increment value; a coincident tick is dropped.
                        rt_ms <= count;
                        valid <= 1'b1;
                        state <= S_DONE;
                    end else if (tick_ms) begin
                        if (count == LAST_V) begin
                            count   <= MAX_V;
                            rt_ms   <= MAX_V;
                            timeout <= 1'b1;
                            state   <= S_TOUT;
                        end else begin
                            count <= count + 14'd1;
                        end
                    end
                end
                S_DONE, S_JUMP, S_TOUT: begin
                    if (arm) begin
                        state      <= S_ARMED;
                        jump_start <= 1'b0;
                        timeout    <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Best-time tracker: valid marks the clock where rt_ms holds a fresh
    // genuine result; clear_best overrides a coincident update.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_ms <= MAX_V;
        end else if (clear_best) begin
            best_ms <= MAX_V;
        end else if (valid && (rt_ms < best_ms)) begin
            best_ms <= rt_ms;
        end
    end

    // busy decodes the state register only.
    assign busy = (state == S_ARMED) || (state == S_TIMING);

endmodule

// File: tb/tb_reaction_timer.sv
// Purpose: randomized self-checking bench for reaction_timer against a per-run scoreboard.
// Latency: expects press effect 3 clks after resp rises and best_ms one clk after valid.
// Backpressure: none; the bench drives fixed-length cycle sequences with no open-ended waits.
module tb_reaction_timer;

    localparam int MAX_MS = 9999;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_ms;
    logic        arm;
    logic        lights_out;
    logic        resp;
    logic        clear_best;
    logic [13:0] rt_ms;
    logic [13:0] best_ms;
    logic        valid;
    logic        jump_start;
    logic        timeout;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    int model_best = MAX_MS;

    reaction_timer #(.MAX_MS(MAX_MS)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_ms    (tick_ms),
        .arm        (arm),
        .lights_out (lights_out),
        .resp       (resp),
        .clear_best (clear_best),
        .rt_ms      (rt_ms),
        .best_ms    (best_ms),
        .valid      (valid),
        .jump_start (jump_start),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    // Count every clock in which valid is high.
    always @(negedge clk) begin
        if (valid) valid_seen++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic release_button();
        resp = 1'b0;
        repeat (4) step();
    endtask

    task automatic arm_pulse(input string tag);
        arm = 1'b1;
        step();
        arm = 1'b0;
        chk({tag, "_arm_busy"}, busy, 1);
        chk({tag, "_arm_jump"}, jump_start, 0);
        chk({tag, "_arm_tout"}, timeout, 0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rt"}, rt_ms, 0);
        chk({tag, "_best"}, best_ms, MAX_MS);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_jump"}, jump_start, 0);
        chk({tag, "_tout"}, timeout, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    // One full measurement. Expected reaction time is the number of ticks
    // the bench delivered after lights_out and before the clock on which the
    // synchronized press lands (that clock's own tick does not count).
    // pipe_mode: ticks during the 3 synchronizer clocks, 0 none, 1 all, 2 random.
    task automatic timed_run(input string tag, input int pre_ticks, input int gap_max,
                             input int pipe_mode, input bit clear_at_update);
        int n;
        int v0;
        arm_pulse(tag);
        repeat ($urandom_range(0, 3)) begin
            tick_ms = 1'($urandom_range(0, 1));
            step();
        end
        tick_ms = 1'b0;
        lights_out = 1'b1;
        step();
        lights_out = 1'b0;
        n = 0;
        for (int i = 0; i < pre_ticks; i++) begin
            repeat ($urandom_range(0, gap_max)) step();
            tick_ms = 1'b1;
            step();
            tick_ms = 1'b0;
            n++;
        end
        v0 = valid_seen;
        resp = 1'b1;
        for (int p = 0; p < 3; p++) begin
            if (pipe_mode == 1) tick_ms = 1'b1;
            else if (pipe_mode == 2) tick_ms = 1'($urandom_range(0, 1));
            else tick_ms = 1'b0;
            if (p == 0) begin
                arm = 1'($urandom_range(0, 1));
                lights_out = 1'($urandom_range(0, 1));
            end
            step();
            arm = 1'b0;
            lights_out = 1'b0;
            if (p < 2 && tick_ms) n++;
        end
        tick_ms = 1'b0;
        chk({tag, "_early_valid"}, valid_seen, v0);
        chk({tag, "_valid"}, valid, 1);
        chk({tag, "_rt"}, rt_ms, n);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_best_hold"}, best_ms, model_best);
        clear_best = clear_at_update;
        step();
        clear_best = 1'b0;
        if (clear_at_update) model_best = MAX_MS;
        else if (n < model_best) model_best = n;
        chk({tag, "_valid_drop"}, valid, 0);
        chk({tag, "_best"}, best_ms, model_best);
        chk({tag, "_valid_count"}, valid_seen, v0 + 1);
        release_button();
    endtask

    // Press before lights_out; with_lights makes lights_out coincide with the press.
    task automatic jump_run(input string tag, input bit with_lights);
        int v0;
        arm_pulse(tag);
        repeat (2) step();
        v0 = valid_seen;
        resp = 1'b1;
        step();
        step();
        lights_out = with_lights;
        step();
        lights_out = 1'b0;
        chk({tag, "_jump"}, jump_start, 1);
        chk({tag, "_rt"}, rt_ms, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_tout"}, timeout, 0);
        lights_out = 1'b1;
        step();
        lights_out = 1'b0;
        step();
        chk({tag, "_late_lights_busy"}, busy, 0);
        chk({tag, "_late_lights_jump"}, jump_start, 1);
        chk({tag, "_best"}, best_ms, model_best);
        chk({tag, "_no_valid"}, valid_seen, v0);
        release_button();
    endtask

    task automatic timeout_run();
        int v0;
        arm_pulse("tout");
        lights_out = 1'b1;
        step();
        lights_out = 1'b0;
        v0 = valid_seen;
        tick_ms = 1'b1;
        repeat (MAX_MS - 1) step();
        chk("tout_before", timeout, 0);
        chk("tout_busy_before", busy, 1);
        step();
        chk("tout_flag", timeout, 1);
        chk("tout_rt", rt_ms, MAX_MS);
        chk("tout_busy", busy, 0);
        repeat (5) step();
        tick_ms = 1'b0;
        chk("tout_rt_sat", rt_ms, MAX_MS);
        chk("tout_best", best_ms, model_best);
        chk("tout_no_valid", valid_seen, v0);
        chk("tout_jump", jump_start, 0);
    endtask

    task automatic reset_mid_timing();
        int v0;
        arm_pulse("rst80");
        lights_out = 1'b1;
        step();
        lights_out = 1'b0;
        tick_ms = 1'b1;
        repeat (80) step();
        tick_ms = 1'b0;
        v0 = valid_seen;
        // Button goes down together with reset and stays held past it.
        resp = 1'b1;
        rst = 1'b1;
        step();
        step();
        check_reset_values("rst80_in");
        rst = 1'b0;
        model_best = MAX_MS;
        repeat (6) step();
        check_reset_values("rst80_after");
        chk("rst80_no_valid", valid_seen, v0);
        arm_pulse("held");
        lights_out = 1'b1;
        step();
        lights_out = 1'b0;
        tick_ms = 1'b1;
        repeat (20) step();
        tick_ms = 1'b0;
        chk("held_no_press_busy", busy, 1);
        chk("held_no_valid", valid_seen, v0);
        resp = 1'b0;
        repeat (4) step();
        resp = 1'b1;
        repeat (3) step();
        chk("held_repress_valid", valid, 1);
        chk("held_repress_rt", rt_ms, 20);
        step();
        model_best = 20;
        chk("held_repress_best", best_ms, model_best);
        release_button();
    endtask

    initial begin
        rst = 1'b1;
        tick_ms = 1'b0;
        arm = 1'b0;
        lights_out = 1'b0;
        resp = 1'b0;
        clear_best = 1'b0;
        repeat (3) step();
        check_reset_values("reset");
        rst = 1'b0;
        repeat (5) step();
        model_best = MAX_MS;

        timed_run("r237", 237, 0, 0, 1'b0);
        jump_run("jump", 1'b0);

        clear_best = 1'b1;
        step();
        clear_best = 1'b0;
        model_best = MAX_MS;
        chk("clear1_best", best_ms, MAX_MS);

        timed_run("r412", 412, 0, 0, 1'b0);
        timed_run("r305", 305, 0, 0, 1'b0);
        timed_run("r500", 500, 0, 0, 1'b0);
        clear_best = 1'b1;
        step();
        clear_best = 1'b0;
        model_best = MAX_MS;
        chk("clear2_best", best_ms, MAX_MS);

        timeout_run();
        jump_run("jump_lights", 1'b1);
        timed_run("c150", 148, 0, 1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            timed_run($sformatf("rand%0d", k), int'($urandom_range(0, 500)),
                      int'($urandom_range(0, 2)), 2, (k == 3));
        end

        reset_mid_timing();
        timed_run("post_rst", 64, 1, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
